// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// multicycle_datapath: multicycle RV32I-subset core, unified req/ack memory port
// Revision 1.0
// ============================================================================
module multicycle_datapath #(
    parameter int               XLEN     = 32,
    parameter int               NREG     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i,
    output logic [XLEN-1:0] pc_o,
    output logic [3:0]      state_o,
    output logic            retire_o,
    output logic            illegal_o
);
    localparam int         RW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_LIM = 6'(NREG);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BEQ     = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_ILLEGAL = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]      state;
    logic [XLEN-1:0] pc, old_pc, a, b, alu_out, mdr;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [NREG];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic xfer;
    assign xfer = mem_req_o & mem_ack_i;

    // Decode: target state plus which register fields must lie below NREG
    logic [3:0] dec_next;
    logic       use_rd, use_rs1, use_rs2, alu_f3_ok;
    always_comb begin
        dec_next  = S_ILLEGAL;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                    (funct3 == 3'b110) || (funct3 == 3'b010);
        case (opcode)
            OP_LW:  if (funct3 == 3'b010) begin
                        dec_next = S_MEMADR; use_rd = 1'b1; use_rs1 = 1'b1;
                    end
            OP_SW:  if (funct3 == 3'b010) begin
                        dec_next = S_MEMADR; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    end
            OP_R:   if ((funct7 == 7'h00 && alu_f3_ok) || (funct7 == 7'h20 && funct3 == 3'b000)) begin
                        dec_next = S_EXECR; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    end
            OP_I:   if (alu_f3_ok) begin
                        dec_next = S_EXECI; use_rd = 1'b1; use_rs1 = 1'b1;
                    end
            OP_BR:  if (funct3 == 3'b000) begin
                        dec_next = S_BEQ; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    end
            OP_JAL: begin
                        dec_next = S_JAL; use_rd = 1'b1;
                    end
            default: dec_next = S_ILLEGAL;
        endcase
        if ((use_rd  && {1'b0, rd}  >= NREG_LIM) ||
            (use_rs1 && {1'b0, rs1} >= NREG_LIM) ||
            (use_rs2 && {1'b0, rs2} >= NREG_LIM))
            dec_next = S_ILLEGAL;
    end

    logic [2:0]      alu_sel;
    logic [XLEN-1:0] alu_rhs, alu_res;
    always_comb begin
        case (funct3)
            3'b000:  alu_sel = (state == S_EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_sel = ALU_AND;
            3'b110:  alu_sel = ALU_OR;
            3'b010:  alu_sel = ALU_SLT;
            default: alu_sel = ALU_ADD;
        endcase
        alu_rhs = (state == S_EXECR) ? b : imm_i;
        case (alu_sel)
            ALU_SUB: alu_res = a - alu_rhs;
            ALU_AND: alu_res = a & alu_rhs;
            ALU_OR:  alu_res = a | alu_rhs;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(alu_rhs))};
            default: alu_res = a + alu_rhs;
        endcase
    end

    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_out;
        case (state)
            S_MEMWB: begin rf_we = 1'b1; rf_wdata = mdr; end
            S_ALUWB: begin rf_we = 1'b1; rf_wdata = alu_out; end
            S_JAL:   begin rf_we = 1'b1; rf_wdata = old_pc + XLEN'(4); end
            default: rf_we = 1'b0;
        endcase
        if (rd == 5'd0)
            rf_we = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (rf_we) begin
            rf[rd[RW-1:0]] <= rf_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            old_pc  <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: if (xfer) begin
                    ir     <= mem_rdata_i[31:0];
                    old_pc <= pc;
                    pc     <= pc + XLEN'(4);
                    state  <= S_DECODE;
                end
                S_DECODE: begin
                    a       <= rf[rs1[RW-1:0]];
                    b       <= rf[rs2[RW-1:0]];
                    alu_out <= old_pc + ((opcode == OP_JAL) ? imm_j : imm_b);
                    state   <= dec_next;
                end
                S_MEMADR: begin
                    alu_out <= a + ((opcode == OP_SW) ? imm_s : imm_i);
                    state   <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: if (xfer) begin
                    mdr   <= mem_rdata_i;
                    state <= S_MEMWB;
                end
                S_MEMWR: if (xfer) state <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    alu_out <= alu_res;
                    state   <= S_ALUWB;
                end
                S_MEMWB, S_ALUWB: state <= S_FETCH;
                S_BEQ: begin
                    if (a == b)
                        pc <= alu_out;
                    state <= S_FETCH;
                end
                S_JAL: begin
                    pc    <= alu_out;
                    state <= S_FETCH;
                end
                S_ILLEGAL: state <= S_ILLEGAL;
                default:   state <= S_ILLEGAL;
            endcase
        end
    end

    // Request drops combinationally with reset so an in-flight transfer is abandoned at once
    assign mem_req_o   = ~reset_i & ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
    assign mem_we_o    = ~reset_i & (state == S_MEMWR);
    assign mem_addr_o  = (state == S_FETCH) ? pc : alu_out;
    assign mem_wdata_o = b;
    assign retire_o    = ~reset_i & ((state == S_MEMWB) || (state == S_ALUWB) ||
                                     (state == S_BEQ)   || (state == S_JAL)   ||
                                     (state == S_MEMWR && mem_ack_i));
    assign illegal_o   = (state == S_ILLEGAL);
    assign pc_o        = pc;
    assign state_o     = state;

endmodule
`default_nettype wire
